// File: rtl/arp_requester.sv
// ARP initiator: broadcasts an ARP request for req_ip on the egress stream, then
// watches the ingress stream for the matching reply, retrying on timeout.
module arp_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [47:0] mac_addr,
  input  logic [31:0] ip_addr,
  input  logic [31:0] req_ip,
  input  logic        req_valid,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_ok,
  output logic [47:0] resp_mac,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned FRAME_W   = 384;
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    R_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t        state;
  logic [31:0]   tgt_ip;
  logic [3:0]    retry_cnt;
  logic [TW-1:0] timer;
  logic [2:0]    tx_beat;
  logic [2:0]    tx_nxt_c;

  logic [2:0]    rx_beat;
  logic          rx_ok;
  logic [47:0]   rx_sha;
  logic          rx_beat_ok_c;
  logic          rx_ok_c;
  logic          rx_match_c;
  logic          unused_keep;

  logic [FRAME_W-1:0] tx_frame_c;

  // Whole request frame, wire byte 0 in the MSBs, padded to six full beats.
  assign tx_frame_c = {48'hFFFF_FFFF_FFFF, mac_addr, 16'h0806, 16'h0001, 16'h0800,
                       16'h0604, 16'h0001, mac_addr, ip_addr, 48'h0, tgt_ip, 48'h0};
  assign tx_nxt_c   = tx_beat + 3'd1;

  function automatic logic [63:0] beat_word(input logic [2:0] b, input logic [FRAME_W-1:0] f);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = f[FRAME_W - 1 - 8*(8*int'(b) + i) -: 8];
    end
    return w;
  endfunction

  assign s_axis_tready = 1'b1;
  assign unused_keep   = ^s_axis_tkeep[7:2];

  // Per-beat field check of the ingress frame.
  always_comb begin
    rx_beat_ok_c = 1'b1;
    case (rx_beat)
      3'd1: rx_beat_ok_c = (s_axis_tdata[63:32] == 32'h0100_0608);
      3'd2: rx_beat_ok_c = (s_axis_tdata[47:0] == 48'h0200_0406_0008);
      3'd3: rx_beat_ok_c = (s_axis_tdata[63:32] ==
                            {tgt_ip[7:0], tgt_ip[15:8], tgt_ip[23:16], tgt_ip[31:24]});
      3'd4: rx_beat_ok_c = (s_axis_tdata[63:48] == {ip_addr[23:16], ip_addr[31:24]});
      3'd5: rx_beat_ok_c = (s_axis_tdata[15:0] == {ip_addr[7:0], ip_addr[15:8]}) &&
                           (s_axis_tkeep[1:0] == 2'b11);
      default: rx_beat_ok_c = 1'b1;
    endcase
  end

  assign rx_ok_c    = (rx_ok || (rx_beat == 3'd0)) && rx_beat_ok_c;
  assign rx_match_c = s_axis_tvalid && s_axis_tlast && rx_ok_c && (rx_beat >= 3'd5);

  // Ingress parser: beat index saturates past the ARP payload so padding is ignored.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_beat <= 3'd0;
      rx_ok   <= 1'b0;
      rx_sha  <= 48'h0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast) begin
        rx_beat <= 3'd0;
      end else if (rx_beat != 3'd6) begin
        rx_beat <= rx_beat + 3'd1;
      end
      rx_ok <= rx_ok_c;
      if (rx_beat == 3'd2) begin
        rx_sha[47:32] <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
      end
      if (rx_beat == 3'd3) begin
        rx_sha[31:0] <= {s_axis_tdata[7:0], s_axis_tdata[15:8],
                         s_axis_tdata[23:16], s_axis_tdata[31:24]};
      end
    end
  end

  // Request / retry sequencer; a reply match takes priority over timer expiry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      tgt_ip        <= 32'h0;
      retry_cnt     <= 4'h0;
      timer         <= '0;
      tx_beat       <= 3'd0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_ok       <= 1'b0;
      resp_mac      <= 48'h0;
      m_axis_tdata  <= 64'h0;
      m_axis_tkeep  <= 8'h0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready     <= 1'b0;
            tgt_ip        <= req_ip;
            retry_cnt     <= 4'h0;
            tx_beat       <= 3'd0;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= beat_word(3'd0, tx_frame_c);
            m_axis_tkeep  <= 8'hFF;
            m_axis_tlast  <= 1'b0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tvalid && m_axis_tready) begin
            if (tx_beat == 3'd5) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= 64'h0;
              m_axis_tkeep  <= 8'h0;
              m_axis_tlast  <= 1'b0;
              timer         <= '0;
              state         <= WAIT;
            end else begin
              tx_beat      <= tx_nxt_c;
              m_axis_tdata <= beat_word(tx_nxt_c, tx_frame_c);
              m_axis_tkeep <= (tx_nxt_c == 3'd5) ? 8'h03 : 8'hFF;
              m_axis_tlast <= (tx_nxt_c == 3'd5);
            end
          end
        end
        WAIT: begin
          if (rx_match_c) begin
            resp_valid <= 1'b1;
            resp_ok    <= 1'b1;
            resp_mac   <= rx_sha;
            state      <= DONE;
          end else if (timer == T_LAST) begin
            if (retry_cnt < R_MAX) begin
              retry_cnt     <= retry_cnt + 4'h1;
              tx_beat       <= 3'd0;
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= beat_word(3'd0, tx_frame_c);
              m_axis_tkeep  <= 8'hFF;
              m_axis_tlast  <= 1'b0;
              state         <= SEND;
            end else begin
              resp_valid <= 1'b1;
              resp_ok    <= 1'b0;
              state      <= DONE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_requester.sv
// Directed bench for arp_requester: a byte-level frame model plus timing rules
// checked every cycle, with hand-computed literals pinning the first frame.
module tb_arp_requester;

  localparam int unsigned TO = 16;
  localparam int unsigned MR = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [47:0] mac_addr;
  logic [31:0] ip_addr;
  logic [31:0] req_ip;
  logic        req_valid;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ok;
  logic [47:0] resp_mac;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;

  arp_requester #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .aclk(aclk), .aresetn(aresetn), .mac_addr(mac_addr), .ip_addr(ip_addr),
    .req_ip(req_ip), .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_mac(resp_mac),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int post_rst = 0;

  int          beat_idx = 0;
  bit          in_frame = 0;
  bit          active = 0;
  int          frames_in_req = 0;
  int          hs_cyc = 0;
  int          last_tlast = 0;
  logic [31:0] tgt = 32'h0;
  logic [63:0] prev_data = 64'h0;
  bit          prev_stall = 0;
  logic [63:0] cap [6];
  logic [7:0]  capk [6];
  logic [47:0] last_mac = 48'h0;

  int          exp_resp_cyc = -1;
  bit          exp_ok = 0;
  logic [47:0] exp_mac = 48'h0;
  bit          bp_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Request frame byte k as listed field by field.
  function automatic logic [7:0] model_byte(input int k);
    logic [7:0] hdr [10];
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    if (k < 6)  return 8'hFF;
    if (k < 12) return mac_addr[8*(11-k) +: 8];
    if (k < 22) return hdr[k-12];
    if (k < 28) return mac_addr[8*(27-k) +: 8];
    if (k < 32) return ip_addr[8*(31-k) +: 8];
    if (k < 38) return 8'h00;
    if (k < 42) return tgt[8*(41-k) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [63:0] exp_word(input int b);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = model_byte(8*b + i);
    return w;
  endfunction

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (!aresetn) post_rst <= 0;
    else post_rst <= post_rst + 1;
  end

  // Compare process: reset values, frame content/timing and result pulses.
  always @(negedge aclk) begin
    if (!aresetn) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_ok", 64'(resp_ok), 64'd0);
      check("rst_resp_mac", 64'(resp_mac), 64'd0);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
      check("rst_tdata", m_axis_tdata, 64'd0);
      check("rst_s_tready", 64'(s_axis_tready), 64'd1);
      beat_idx = 0; in_frame = 0; active = 0; prev_stall = 0; frames_in_req = 0;
    end else begin
      check("s_tready", 64'(s_axis_tready), 64'd1);
      if (post_rst >= 1) begin
        check("req_ready", 64'(req_ready), 64'(!active));
        if (req_valid && req_ready) begin
          hs_cyc = cyc; active = 1; frames_in_req = 0; tgt = req_ip;
        end
      end
      if (m_axis_tvalid) begin
        if (!in_frame) begin
          in_frame = 1;
          check("tx_while_busy", 64'(active), 64'd1);
          check("tx_start_cycle", 64'(cyc),
                64'((frames_in_req == 0) ? hs_cyc + 1 : last_tlast + int'(TO) + 1));
          check("tx_attempt_limit", 64'(frames_in_req < int'(MR) + 1), 64'd1);
        end
        if (prev_stall) check("tx_stable", m_axis_tdata, prev_data);
        check("tx_tdata", m_axis_tdata, exp_word(beat_idx));
        check("tx_tkeep", 64'(m_axis_tkeep), (beat_idx == 5) ? 64'h03 : 64'hFF);
        check("tx_tlast", 64'(m_axis_tlast), 64'(beat_idx == 5));
        prev_stall = !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (m_axis_tready) begin
          cap[beat_idx]  = m_axis_tdata;
          capk[beat_idx] = m_axis_tkeep;
          if (beat_idx == 5) begin
            beat_idx = 0; in_frame = 0; frames_in_req++; last_tlast = cyc;
          end else begin
            beat_idx++;
          end
        end
      end else begin
        prev_stall = 0;
        if (in_frame) check("tx_valid_in_frame", 64'(m_axis_tvalid), 64'd1);
      end
      check("resp_valid", 64'(resp_valid), 64'(cyc == exp_resp_cyc));
      if (resp_valid && cyc == exp_resp_cyc) begin
        check("resp_ok", 64'(resp_ok), 64'(exp_ok));
        if (exp_ok) check("resp_mac", 64'(resp_mac), 64'(exp_mac));
        last_mac = resp_mac;
        active = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (bp_en) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic request(input logic [31:0] ip);
    int n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_ip = ip; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_in_req < n && k < 400) begin tick(); k++; end
    check("frames_reached", 64'(frames_in_req), 64'(n));
  endtask

  task automatic wait_done();
    int k = 0;
    while (active && k < 300) begin tick(); k++; end
    check("request_finished", 64'(active), 64'd0);
    tick();
  endtask

  task automatic send_reply(input logic [47:0] sha, input logic [31:0] spa,
                            input logic [15:0] oper, input int nbytes, input bit match);
    logic [7:0] rb [64];
    int nb;
    for (int i = 0; i < 64; i++) rb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      rb[i]    = mac_addr[8*(5-i) +: 8];
      rb[6+i]  = sha[8*(5-i) +: 8];
      rb[22+i] = sha[8*(5-i) +: 8];
      rb[32+i] = mac_addr[8*(5-i) +: 8];
    end
    rb[12] = 8'h08; rb[13] = 8'h06; rb[14] = 8'h00; rb[15] = 8'h01;
    rb[16] = 8'h08; rb[17] = 8'h00; rb[18] = 8'h06; rb[19] = 8'h04;
    rb[20] = oper[15:8]; rb[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      rb[28+i] = spa[8*(3-i) +: 8];
      rb[38+i] = ip_addr[8*(3-i) +: 8];
    end
    nb = (nbytes + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++) begin
        s_axis_tdata[8*i +: 8] = (8*b + i < nbytes) ? rb[8*b + i] : 8'h00;
        s_axis_tkeep[i]        = (8*b + i < nbytes);
      end
      s_axis_tlast  = (b == nb - 1);
      s_axis_tvalid = 1'b1;
      if (b == nb - 1 && match) begin
        exp_resp_cyc = cyc + 1; exp_ok = 1; exp_mac = sha;
      end
      tick();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 64'h0; s_axis_tkeep = 8'h0;
  endtask

  initial begin
    int t;
    int n;
    aresetn = 1'b0; mac_addr = 48'h02_00_00_00_00_01; ip_addr = 32'hC0A8_0A02;
    req_ip = 32'h0; req_valid = 1'b0; m_axis_tready = 1'b1;
    s_axis_tdata = 64'h0; s_axis_tkeep = 8'h0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick(); tick();
    check("req_ready_after_rst", 64'(req_ready), 64'd1);

    // Resolve, with literal pins on the first frame.
    request(32'hC0A8_0A01);
    wait_frames(1);
    check("lit_beat0", cap[0], 64'h0002_FFFF_FFFF_FFFF);
    check("lit_beat1", cap[1], 64'h0100_0608_0100_0000);
    check("lit_beat3", cap[3], 64'h020A_A8C0_0100_0000);
    check("lit_beat4", cap[4], 64'hA8C0_0000_0000_0000);
    check("lit_beat5", cap[5], 64'h0000_0000_0000_010A);
    check("lit_keep5", 64'(capk[5]), 64'h03);
    send_reply(48'h00_11_22_33_44_55, 32'hC0A8_0A01, 16'h0002, 42, 1);
    wait_done();
    check("lit_resp_mac", 64'(last_mac), 64'h0000_0011_2233_4455);

    // Filtering: one bad reply per attempt, then a good one.
    request(32'hC0A8_0A01);
    wait_frames(1);
    send_reply(48'h66_77_88_99_AA_BB, 32'hC0A8_0A09, 16'h0002, 42, 0);
    wait_frames(2);
    send_reply(48'h66_77_88_99_AA_BB, 32'hC0A8_0A01, 16'h0001, 42, 0);
    wait_frames(3);
    send_reply(48'h66_77_88_99_AA_BB, 32'hC0A8_0A01, 16'h0002, 40, 0);
    send_reply(48'hAA_BB_CC_DD_EE_FF, 32'hC0A8_0A01, 16'h0002, 42, 1);
    wait_done();
    check("lit_filter_mac", 64'(last_mac), 64'h0000_AABB_CCDD_EEFF);

    // Timeout: three attempts, then a failure pulse.
    request(32'hC0A8_0A07);
    wait_frames(3);
    exp_resp_cyc = last_tlast + int'(TO) + 1; exp_ok = 0;
    wait_done();
    check("timeout_attempts", 64'(frames_in_req), 64'd3);

    // Backpressure on the egress path.
    bp_en = 1;
    request(32'hC0A8_0A01);
    wait_frames(1);
    bp_en = 0; m_axis_tready = 1'b1;
    send_reply(48'h12_34_56_78_9A_BC, 32'hC0A8_0A01, 16'h0002, 42, 1);
    wait_done();

    // Race: reply tlast lands in the timer's last cycle.
    request(32'hC0A8_0A01);
    wait_frames(1);
    t = last_tlast;
    n = 0;
    while (cyc < t + int'(TO) - 5 && n < 50) begin tick(); n++; end
    send_reply(48'h0A_0B_0C_0D_0E_0F, 32'hC0A8_0A01, 16'h0002, 42, 1);
    wait_done();
    check("race_no_retx", 64'(frames_in_req), 64'd1);

    // Padded 60-byte reply.
    request(32'hC0A8_0A01);
    wait_frames(1);
    send_reply(48'hDE_AD_BE_EF_00_01, 32'hC0A8_0A01, 16'h0002, 60, 1);
    wait_done();

    // Reset in the middle of the request frame.
    request(32'hC0A8_0A05);
    n = 0;
    while (!(m_axis_tvalid && beat_idx == 3) && n < 50) begin tick(); n++; end
    check("reached_beat3", 64'(beat_idx), 64'd3);
    aresetn = 1'b0;
    #1;
    check("tvalid_async_rst", 64'(m_axis_tvalid), 64'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick(); tick();
    request(32'hC0A8_0A01);
    wait_frames(1);
    send_reply(48'h55_44_33_22_11_00, 32'hC0A8_0A01, 16'h0002, 42, 1);
    wait_done();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
